// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for a word-addressed data RAM.
// The RAM has a registered read port with one cycle of latency and a byte-enabled write port.
// The controller handles one RV32I load or store at a time: the request is checked,
// then the RAM is read or written, then a response is returned.
module lsu_mem_ctrl #(
  parameter int RAM_WORDS = 501
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [29:0] ram_addr,
  input  logic [31:0] ram_rdata,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_byte_en
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [31:0] RAM_WORDS_U = 32'(RAM_WORDS);

  logic [2:0]  state_q,      state_d;
  logic [31:0] addr_q,       addr_d;
  logic [2:0]  funct3_q,     funct3_d;
  logic [29:0] ram_addr_q,   ram_addr_d;
  logic [31:0] ram_wdata_q,  ram_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q,   resp_err_d;
  logic        accept;

  // An access is rejected when funct3 is illegal, the access is misaligned, or the word is out of range.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic f3_bad;
    logic misal;
    logic oor;
    f3_bad = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    misal  = ((f3[1:0] == 2'b01) && addr[0]) ||
             ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    oor    = {2'b00, addr[31:2]} >= RAM_WORDS_U;
    return f3_bad | misal | oor;
  endfunction

  // Select the addressed byte or halfword from the RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Copy the store data into every lane, so the byte enables alone choose which lanes the RAM writes.
  function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Compute the byte lanes to write from the store width and the address offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign accept = req_valid && (state_q == S_IDLE);

  // Next-state and datapath update for the request/response sequencing.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          if (access_err(req_we, req_funct3, req_addr)) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = S_RESP;
          end else begin
            // The RAM address is set up here so that it is already stable in ISSUE and WRITE.
            ram_addr_d = req_addr[31:2];
            if (req_we) begin
              ram_wdata_d = store_rep(req_funct3, req_wdata);
              state_d     = S_WRITE;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_ISSUE: state_d = S_CAPT;
      S_CAPT: begin
        resp_rdata_d = load_fmt(funct3_q, addr_q[1:0], ram_rdata);
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_WRITE: begin
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, response and RAM-side registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ram_addr_q   <= 30'h0;
      ram_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Latched request fields; they are only read in states that an accept has already filled in.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    funct3_q <= funct3_d;
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  // The write strobes are gated by rst directly, so that no write lands on an edge where reset is sampled.
  assign ram_we      = (state_q == S_WRITE) && !rst;
  assign ram_byte_en = ram_we ? store_be(funct3_q, addr_q[1:0]) : 4'b0000;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: a model RAM, directed vector table, corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_lsu_mem_ctrl;

  localparam int RAM_WORDS = 501;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [29:0] ram_addr;
  logic [31:0] ram_rdata;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byte_en;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_ctrl #(.RAM_WORDS(RAM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_byte_en(ram_byte_en)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, byte-lane write; contents are cleared on the first edge.
  logic [31:0] mem [RAM_WORDS];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < RAM_WORDS; i++) mem[i] <= 32'h0;
      mem_init <= 1'b1;
    end else if (ram_byte_en != 4'b0 && int'(ram_addr) < RAM_WORDS) begin
      for (int i = 0; i < 4; i++)
        if (ram_byte_en[i]) mem[int'(ram_addr)][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    ram_rdata <= (mem_init && int'(ram_addr) < RAM_WORDS) ? mem[int'(ram_addr)] : 32'h0;
  end

  // Write monitor: counts RAM writes, remembers the last one, and flags any write while rst is high.
  int         n_writes   = 0;
  int         rst_wr_cnt = 0;
  logic [3:0] last_be    = 4'h0;
  logic [29:0] last_waddr = 30'h0;
  always @(posedge clk) begin
    if (rst && (ram_we || ram_byte_en != 4'b0)) rst_wr_cnt <= rst_wr_cnt + 1;
    if (ram_byte_en != 4'b0) begin
      n_writes   <= n_writes + 1;
      last_be    <= ram_byte_en;
      last_waddr <= ram_addr;
    end
  end

  // Reference memory for the behavioural model.
  logic [31:0] ref_mem [RAM_WORDS];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: decides legality, updates ref_mem, and predicts the response and latency.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic er, output int lat);
    int unsigned word;
    int          off;
    int          size;
    bit          legal;
    logic [31:0] w;
    logic [31:0] v;
    word  = a / 4;
    off   = int'(a % 4);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << (f3 % 4);
    er    = !legal || (a % size != 0) || (word >= RAM_WORDS);
    rd    = 32'h0;
    lat   = er ? 1 : (we ? 2 : 3);
    if (!er) begin
      if (we) begin
        w = ref_mem[word];
        for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        ref_mem[word] = w;
      end else begin
        v = ref_mem[word] >> (8*off);
        case (f3)
          3'd0:    rd = 32'($signed(v[7:0]));
          3'd4:    rd = v & 32'hFF;
          3'd1:    rd = 32'($signed(v[15:0]));
          3'd5:    rd = v & 32'hFFFF;
          default: rd = v;
        endcase
      end
    end
  endfunction

  // Runs one request/response exchange. It starts and ends at a negedge, and lat counts cycles from accept to resp_valid.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!resp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_valid_timeout: got 0 expected 1");
      lat = -1;
    end
    repeat (hold) @(negedge clk);
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] rd, mrd, hr;
    logic        er, mer;
    int          lat, mlat, nw;

    tbl[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 4'hF};
    tbl[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3, 4'h0};
    tbl[2]  = '{1'b1, 3'd2, 32'h10,  32'h11223344, 32'h0,        1'b0, 2, 4'hF};
    tbl[3]  = '{1'b1, 3'd0, 32'h13,  32'h00000080, 32'h0,        1'b0, 2, 4'h8};
    tbl[4]  = '{1'b0, 3'd0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0, 3, 4'h0};
    tbl[5]  = '{1'b0, 3'd4, 32'h13,  32'h0,        32'h00000080, 1'b0, 3, 4'h0};
    tbl[6]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h80223344, 1'b0, 3, 4'h0};
    tbl[7]  = '{1'b1, 3'd1, 32'h22,  32'h00008001, 32'h0,        1'b0, 2, 4'hC};
    tbl[8]  = '{1'b0, 3'd1, 32'h22,  32'h0,        32'hFFFF8001, 1'b0, 3, 4'h0};
    tbl[9]  = '{1'b0, 3'd5, 32'h22,  32'h0,        32'h00008001, 1'b0, 3, 4'h0};
    tbl[10] = '{1'b0, 3'd2, 32'h11,  32'h0,        32'h0,        1'b1, 1, 4'h0};
    tbl[11] = '{1'b1, 3'd1, 32'h21,  32'h0000FFFF, 32'h0,        1'b1, 1, 4'h0};
    tbl[12] = '{1'b0, 3'd3, 32'h10,  32'h0,        32'h0,        1'b1, 1, 4'h0};
    tbl[13] = '{1'b0, 3'd2, 32'h7D4, 32'h0,        32'h0,        1'b1, 1, 4'h0};
    tbl[14] = '{1'b1, 3'd4, 32'h10,  32'h000000AA, 32'h0,        1'b1, 1, 4'h0};
    tbl[15] = '{1'b0, 3'd2, 32'h20,  32'h0,        32'h80010000, 1'b0, 3, 4'h0};

    for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = 32'h0;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_byte_en", 32'(ram_byte_en), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'h1);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      nw = n_writes;
      xact(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 0, rd, er, lat);
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mrd, mer, mlat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      if (tbl[i].exp_be != 4'h0) begin
        chk($sformatf("vec%0d_nwrites", i), 32'(n_writes), 32'(nw + 1));
        chk($sformatf("vec%0d_byte_en", i), 32'(last_be), 32'(tbl[i].exp_be));
        chk($sformatf("vec%0d_waddr", i), 32'(last_waddr), tbl[i].addr >> 2);
      end else begin
        chk($sformatf("vec%0d_nowrite", i), 32'(n_writes), 32'(nw));
      end
    end

    // Response back-pressure, with a competing store presented while busy
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("hold_resp_arrives", 32'(resp_valid), 32'h1);
    hr = resp_rdata;
    chk("hold_rdata_value", hr, 32'h80223344);
    nw = n_writes;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_resp_valid", k), 32'(resp_valid), 32'h1);
      chk($sformatf("hold%0d_rdata", k), resp_rdata, hr);
      chk($sformatf("hold%0d_req_ready", k), 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("release_resp_valid", 32'(resp_valid), 32'h0);
    chk("release_req_ready", 32'(req_ready), 32'h1);
    chk("ignored_store_nowrite", 32'(n_writes), 32'(nw));

    // Reset asserted during the WRITE cycle of a store
    nw = n_writes;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstwr_byte_en", 32'(ram_byte_en), 32'h0);
    chk("rstwr_ram_we", 32'(ram_we), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstwr_resp_valid", 32'(resp_valid), 32'h0);
    chk("rstwr_req_ready", 32'(req_ready), 32'h1);
    chk("rstwr_nowrite", 32'(n_writes), 32'(nw));
    xact(1'b0, 3'd2, 32'h40, 32'h0, 0, rd, er, lat);
    model(1'b0, 3'd2, 32'h40, 32'h0, mrd, mer, mlat);
    chk("after_rst_lw_rdata", rd, mrd);
    chk("after_rst_lw_err", 32'(er), 32'(mer));
    chk("after_rst_lw_latency", 32'(lat), 32'(mlat));

    // Randomized traffic against the reference model
    for (int t = 0; t < 300; t++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      int          word;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       word = $urandom_range(RAM_WORDS - 2, RAM_WORDS + 2);
        1:       word = $urandom_range(0, RAM_WORDS - 1);
        default: word = $urandom_range(0, 15);
      endcase
      a = (32'(word) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) a = $urandom;
      wd = $urandom;
      nw = n_writes;
      xact(we, f3, a, wd, $urandom_range(0, 2), rd, er, lat);
      model(we, f3, a, wd, mrd, mer, mlat);
      chk($sformatf("rnd%0d_rdata", t), rd, mrd);
      chk($sformatf("rnd%0d_err", t), 32'(er), 32'(mer));
      chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d_nwrites", t), 32'(n_writes), 32'(nw + ((we && !mer) ? 1 : 0)));
    end

    chk("no_write_during_rst", 32'(rst_wr_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
